uart_tx_ctrl: RTL and testbench

UART transmit sequencer: it accepts one byte per valid/ready handshake and drives an internal shift register and baud-rate divider to serialize the byte onto `txd`. Each frame is: start bit, data LSB first, optional parity, then stop bits. The block sits between the byte-level host logic and the UART pin, and it owns all bit timing and framing.

---
 rtl/uart_tx_ctrl_if.sv | 21 ++
 rtl/uart_tx_ctrl.sv | 118 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Byte-level valid/ready handshake between host logic and the UART transmitter.
// The host drives data/valid; the transmitter answers with ready.
interface uart_tx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts one byte per handshake and serializes it as
// start bit, LSB-first data, optional parity and stop bits onto a registered txd.
module uart_tx_ctrl #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tx_en_i,
  uart_tx_ctrl_if.slave host,
  output logic          txd_o,
  output logic          busy_o,
  output logic          frame_done_o
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = 3;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = 1'b1;

    // With tx_en_i low every register keeps its value, so a paused bit resumes
    // from the held baud count.
    if (tx_en_i) begin
      if (state_q == IDLE) begin
        if (host.tx_valid) begin
          shift_d = host.tx_data;
          par_d   = (^host.tx_data) ^ (PARITY_ODD != 0);
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end else if (!bit_end) begin
        baud_d = baud_q + 1'b1;
      end else begin
        baud_d = '0;
        case (state_q)
          START:  state_d = DATA;
          DATA: begin
            shift_d = shift_q >> 1;
            if (bit_q == DATA_LAST) begin
              bit_d   = '0;
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
          PARITY: state_d = STOP;
          STOP: begin
            if (bit_q == STOP_LAST) begin
              bit_d   = '0;
              state_d = IDLE;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // txd is registered from the next state so the line changes on the same
    // edge as the FSM.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  assign txd_o         = txd_q;
  assign busy_o        = (state_q != IDLE);
  assign host.tx_ready = !rst || ((state_q == IDLE) && tx_en_i);
  assign frame_done_o  = tx_en_i && (state_q == STOP) && bit_end && (bit_q == STOP_LAST);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four configurations (8N1, even parity, odd parity,
// parity with two stop bits) checked cycle by cycle against a frame scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;
  localparam int NDUT = 4;
  localparam int CDIV = 4;

  typedef struct packed {logic txd; logic busy; logic fd;} ent_t;
  localparam ent_t IDLE_ENT = ent_t'(3'b100);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] data_v  [NDUT];
  logic       valid_v [NDUT];
  logic       en_v    [NDUT];
  logic       ready_v [NDUT];
  logic       txd_v   [NDUT];
  logic       busy_v  [NDUT];
  logic       fd_v    [NDUT];

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    uart_tx_ctrl_if #(.DATA_BITS(8)) hif ();
    assign hif.tx_data  = data_v[gi];
    assign hif.tx_valid = valid_v[gi];
    assign ready_v[gi]  = hif.tx_ready;
    uart_tx_ctrl #(
      .CLK_DIV(CDIV), .DATA_BITS(8),
      .PARITY_EN((gi == 0) ? 0 : 1), .PARITY_ODD((gi == 2) ? 1 : 0),
      .STOP_BITS((gi == 3) ? 2 : 1)
    ) u_dut (
      .clk(clk), .rst(rst), .tx_en_i(en_v[gi]), .host(hif),
      .txd_o(txd_v[gi]), .busy_o(busy_v[gi]), .frame_done_o(fd_v[gi])
    );
  end

  ent_t exp_q [$];
  ent_t cur = IDLE_ENT;
  int   sel = 0, cyc = 0, n_cmp = 0, n_bad = 0;
  int   hs_cnt = 0, hs_cyc = 0, fd_cnt = 0, fd_cyc = 0, rdy_cyc = 0;
  logic rst_e = 1'b0, en_e = 1'b0, rdy_prev = 1'b0, exp_rdy, exp_fd;
  logic txd_hist [0:8191];

  // Expected per-cycle line levels of one frame, built from the frame format.
  function automatic void push_frame(input int s, input logic [7:0] d);
    logic bits [$];
    ent_t e;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (s != 0) bits.push_back((^d) ^ (s == 2));
    for (int i = 0; i < ((s == 3) ? 2 : 1); i++) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < CDIV; c++) begin
        e.txd  = bits[b];
        e.busy = 1'b1;
        e.fd   = (b == bits.size() - 1) && (c == CDIV - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  always @(posedge clk) begin
    cyc   = cyc + 1;
    rst_e = rst;
    en_e  = en_v[sel];
  end

  // Scoreboard: the model advances one entry per enabled, non-reset edge.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      cur = IDLE_ENT;
    end else if (rst_e && en_e) begin
      cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_ENT;
    end
    exp_rdy = !rst || (en_v[sel] && !cur.busy);
    exp_fd  = cur.fd && en_v[sel] && rst;
    n_cmp++;
    if (txd_v[sel] !== cur.txd) begin
      n_bad++; $display("FAIL txd dut%0d cycle %0d: got %b want %b", sel, cyc + 1, txd_v[sel], cur.txd);
    end
    n_cmp++;
    if (busy_v[sel] !== cur.busy) begin
      n_bad++; $display("FAIL busy dut%0d cycle %0d: got %b want %b", sel, cyc + 1, busy_v[sel], cur.busy);
    end
    n_cmp++;
    if (fd_v[sel] !== exp_fd) begin
      n_bad++; $display("FAIL frame_done dut%0d cycle %0d: got %b want %b", sel, cyc + 1, fd_v[sel], exp_fd);
    end
    n_cmp++;
    if (ready_v[sel] !== exp_rdy) begin
      n_bad++; $display("FAIL tx_ready dut%0d cycle %0d: got %b want %b", sel, cyc + 1, ready_v[sel], exp_rdy);
    end
    if (cyc + 1 < 8192) txd_hist[cyc + 1] = txd_v[sel];
    if (fd_v[sel] === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc + 1;
    end
    if (ready_v[sel] === 1'b1 && rdy_prev !== 1'b1) rdy_cyc = cyc + 1;
    rdy_prev = ready_v[sel];
    if (rst && exp_rdy && valid_v[sel]) begin
      push_frame(sel, data_v[sel]);
      hs_cnt++;
      hs_cyc = cyc + 1;
      $display("dut%0d: frame 0x%02h accepted at edge %0d", sel, data_v[sel], hs_cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int start, output int hs);
    int t = 0;
    while (hs_cnt == start && t < 300) begin tick(1); t++; end
    n_cmp++;
    if (hs_cnt == start) begin
      n_bad++; $display("FAIL handshake dut%0d: got none in %0d cycles, want one", sel, t);
    end
    hs = hs_cyc;
  endtask

  task automatic send(input logic [7:0] d, output int hs);
    data_v[sel]  = d;
    valid_v[sel] = 1'b1;
    wait_hs(hs_cnt, hs);
    valid_v[sel] = 1'b0;
  endtask

  task automatic wait_fd(input int start);
    int t = 0;
    while (fd_cnt == start && t < 300) begin tick(1); t++; end
    n_cmp++;
    if (fd_cnt == start) begin
      n_bad++; $display("FAIL frame_done_wait dut%0d: got none in %0d cycles, want one", sel, t);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    rst = 1'b0;
    repeat (5) begin
      for (int i = 0; i < NDUT; i++) begin
        en_v[i] = 1'($urandom); valid_v[i] = 1'($urandom); data_v[i] = 8'($urandom);
      end
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        n_cmp++;
        if ({txd_v[i], ready_v[i], busy_v[i], fd_v[i]} !== 4'b1100) begin
          n_bad++;
          $display("FAIL reset_outputs dut%0d: got txd/rdy/busy/fd %b%b%b%b want 1100",
                   i, txd_v[i], ready_v[i], busy_v[i], fd_v[i]);
        end
      end
      tick(1);
    end
    for (int i = 0; i < NDUT; i++) begin en_v[i] = 1'b1; valid_v[i] = 1'b0; data_v[i] = 8'h00; end
    tick(1);
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      n_cmp++;
      if (ready_v[i] !== 1'b1) begin
        n_bad++; $display("FAIL ready_after_reset dut%0d: got %b want 1", i, ready_v[i]);
      end
    end
    tick(1);
  endtask

  task automatic test_basic();
    int hs, f0;
    int pat [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    sel = 0;
    tick(2);
    f0 = fd_cnt;
    send(8'hA5, hs);
    wait_fd(f0);
    n_cmp++;
    if (fd_cyc - hs != 40) begin
      n_bad++; $display("FAIL basic_fd_time: got T+%0d want T+40", fd_cyc - hs);
    end
    tick(3);
    n_cmp++;
    if (rdy_cyc - hs != 41) begin
      n_bad++; $display("FAIL basic_ready_time: got T+%0d want T+41", rdy_cyc - hs);
    end
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (txd_hist[hs + k * CDIV + 2] !== 1'(pat[k])) begin
        n_bad++; $display("FAIL basic_bit%0d: got %b want %0d", k, txd_hist[hs + k * CDIV + 2], pat[k]);
      end
    end
  endtask

  task automatic test_parity();
    int hs, f0;
    logic [7:0] dat [3] = '{8'hA5, 8'h01, 8'hA5};
    int        dut [3] = '{1, 1, 2};
    logic      par [3] = '{1'b0, 1'b1, 1'b1};
    for (int j = 0; j < 3; j++) begin
      sel = dut[j];
      tick(2);
      f0 = fd_cnt;
      send(dat[j], hs);
      wait_fd(f0);
      n_cmp++;
      if (fd_cyc - hs != 44) begin
        n_bad++; $display("FAIL parity_fd_time case%0d: got T+%0d want T+44", j, fd_cyc - hs);
      end
      n_cmp++;
      if (txd_hist[hs + 9 * CDIV + 2] !== par[j]) begin
        n_bad++; $display("FAIL parity_bit case%0d: got %b want %b", j, txd_hist[hs + 9 * CDIV + 2], par[j]);
      end
      tick(2);
    end
  endtask

  task automatic test_back_to_back();
    int hs1, hs2, f0;
    sel = 3;
    tick(2);
    data_v[3]  = 8'h00;
    valid_v[3] = 1'b1;
    wait_hs(hs_cnt, hs1);
    data_v[3] = 8'h3C;
    tick(20);
    data_v[3] = 8'hC3;
    tick(10);
    data_v[3] = 8'hFF;
    wait_hs(hs_cnt, hs2);
    valid_v[3] = 1'b0;
    data_v[3]  = 8'h5A;
    f0 = fd_cnt;
    wait_fd(f0);
    n_cmp++;
    if (hs2 - hs1 != 49) begin
      n_bad++; $display("FAIL b2b_gap: got %0d want 49", hs2 - hs1);
    end
    n_cmp++;
    if ({txd_hist[hs1 + 48], txd_hist[hs1 + 49], txd_hist[hs1 + 50]} !== 3'b110) begin
      n_bad++; $display("FAIL b2b_idle_cycle: got %b%b%b want 110",
                        txd_hist[hs1 + 48], txd_hist[hs1 + 49], txd_hist[hs1 + 50]);
    end
    for (int k = 1; k <= 8; k++) begin
      n_cmp++;
      if (txd_hist[hs1 + k * CDIV + 2] !== 1'b0 || txd_hist[hs2 + k * CDIV + 2] !== 1'b1) begin
        n_bad++; $display("FAIL b2b_data_bit%0d: got %b/%b want 0/1", k - 1,
                          txd_hist[hs1 + k * CDIV + 2], txd_hist[hs2 + k * CDIV + 2]);
      end
    end
    tick(2);
  endtask

  task automatic test_pause();
    int hs, f0, h0;
    sel = 0;
    tick(2);
    f0 = fd_cnt;
    send(8'h0A, hs);
    tick(17 - (cyc - hs));
    en_v[0] = 1'b0;
    tick(3);
    @(negedge clk);
    n_cmp++;
    if (ready_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
      n_bad++; $display("FAIL pause_status: got rdy %b busy %b want 0 1", ready_v[0], busy_v[0]);
    end
    tick(4);
    en_v[0] = 1'b1;
    wait_fd(f0);
    n_cmp++;
    if (fd_cyc - hs != 47) begin
      n_bad++; $display("FAIL pause_fd_time: got T+%0d want T+47", fd_cyc - hs);
    end
    n_cmp++;
    if ({txd_hist[hs + 16], txd_hist[hs + 17], txd_hist[hs + 27], txd_hist[hs + 28]} !== 4'b0110) begin
      n_bad++; $display("FAIL pause_bit3_span: got %b%b%b%b want 0110", txd_hist[hs + 16],
                        txd_hist[hs + 17], txd_hist[hs + 27], txd_hist[hs + 28]);
    end
    tick(2);
    h0 = hs_cnt;
    en_v[0] = 1'b0;
    data_v[0] = 8'h77;
    valid_v[0] = 1'b1;
    tick(3);
    @(negedge clk);
    n_cmp++;
    if (ready_v[0] !== 1'b0 || hs_cnt != h0) begin
      n_bad++; $display("FAIL idle_disabled: got rdy %b accepted %0d want 0 0", ready_v[0], hs_cnt - h0);
    end
    valid_v[0] = 1'b0;
    tick(1);
    en_v[0] = 1'b1;
    tick(2);
  endtask

  task automatic test_reset_mid();
    int hs, f0;
    sel = 0;
    tick(2);
    send(8'hC3, hs);
    tick(17 - (cyc - hs));
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({txd_v[0], busy_v[0], fd_v[0]} !== 3'b100) begin
      n_bad++; $display("FAIL async_reset: got txd/busy/fd %b%b%b want 100", txd_v[0], busy_v[0], fd_v[0]);
    end
    f0 = fd_cnt;
    tick(3);
    rst = 1'b1;
    tick(60);
    n_cmp++;
    if (fd_cnt != f0) begin
      n_bad++; $display("FAIL aborted_frame_done: got %0d pulses want 0", fd_cnt - f0);
    end
    send(8'h96, hs);
    wait_fd(f0);
    n_cmp++;
    if (fd_cyc - hs != 40) begin
      n_bad++; $display("FAIL post_reset_fd_time: got T+%0d want T+40", fd_cyc - hs);
    end
    tick(3);
  endtask

  initial begin
    for (int i = 0; i < NDUT; i++) begin en_v[i] = 1'b1; valid_v[i] = 1'b0; data_v[i] = 8'h00; end
    #2;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_pause();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
